// File: rtl/uart_tx.sv
// uart_tx: buffered serial transmitter for the board UART link.
//
// Bytes from the core are accepted over a valid/ready handshake into a
// small FIFO. An FSM pops them one at a time and shifts each out LSB first
// as an 8N1 frame on io_tx: start bit 0, eight data bits, stop bit 1. Each
// bit is held for CLKS_PER_BIT clocks.
//
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit. The frame is then 8E1, 11 bits.
// With the macro left undefined the frame is 8N1, 10 bits, and no parity
// logic exists.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (>= 2)
//   FIFO_DEPTH    byte FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset; aborts any frame and
//               flushes the FIFO
//   tx_data     byte to send, sampled when tx_valid && tx_ready
//   tx_valid    producer has a byte
//   tx_ready    FIFO has room (fifo_count < FIFO_DEPTH)
//   io_tx       serial line, idle high, registered
//   busy        FSM not idle or FIFO non-empty
//   fifo_count  bytes buffered, excluding the byte in flight
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic                         io_tx,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
  localparam logic [2:0]    LAST_BIT  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  // ---------------------------------------------------------------------
  // Byte FIFO
  // ---------------------------------------------------------------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic [7:0]    head;

  // tx_ready is a function of the count alone. When the FIFO is full, a pop
  // in the same cycle cannot admit a push; the slot opens a cycle later.
  assign tx_ready   = (count_q != FULL);
  assign push       = tx_valid && tx_ready;
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];

  // Storage has no reset. A flush only needs the pointers and the count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  // ---------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------
  state_t        state_q,   state_d;
  logic [BW-1:0] baud_q,    baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q,   shift_d;
  logic          tx_q,      tx_d;
`ifdef UART_TX_PARITY_EN
  logic          parity_q,  parity_d;
`endif

  logic bit_end;
  assign bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d   = state_q;
    baud_d    = bit_end ? '0 : baud_q + BW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    pop       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        if (!fifo_empty) begin
          // The start bit is driven on the same edge that pops the byte.
          pop     = 1'b1;
          shift_d = head;
`ifdef UART_TX_PARITY_EN
          parity_d = ^head;
`endif
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end

      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end
      end

      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = parity_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            // shift_q[0] is on the line now, so the next bit is shift_q[1].
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif

      S_STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            // Start the next frame directly, with no idle bit between.
            // baud_d has already wrapped to 0.
            pop     = 1'b1;
            shift_d = head;
`ifdef UART_TX_PARITY_EN
            parity_d = ^head;
`endif
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // FIFO pointer/count next state. Simultaneous push and pop leaves the
  // count unchanged while both pointers advance.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  assign io_tx      = tx_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed, table-driven bench for uart_tx at CLKS_PER_BIT=4,
// FIFO_DEPTH=4. Inputs change just after the rising edge. Outputs are
// sampled on the falling edge.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       io_tx;
  logic       busy;
  logic [2:0] fifo_count;

  int checks   = 0;
  int failures = 0;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .io_tx      (io_tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  // Each vector holds a byte and its hand-computed even parity.
  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  vec_t vecs [8];

  // frame[0] is the start bit, which goes on the line first.
  function automatic logic [10:0] mk_frame(input vec_t v);
`ifdef UART_TX_PARITY_EN
    return {1'b1, v.par, v.data, 1'b0};
`else
    return {1'b0, 1'b1, v.data, 1'b0};
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Call this when positioned at or just after the edge that drives the
  // start bit. Each bit must hold its value for all CPB cycles.
  task automatic check_frame(input logic [10:0] fr, input string nm);
    logic bad;
    logic got;
    for (int i = 0; i < NB; i++) begin
      bad = 1'b0;
      got = fr[i];
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        if (io_tx !== fr[i]) begin
          bad = 1'b1;
          got = io_tx;
        end
      end
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL %s bit%0d io_tx=%b exp=%b", nm, i, got, fr[i]);
      end
    end
  endtask

  // Presents a byte and returns 1 time unit after the edge that accepts it.
  task automatic push(input logic [7:0] d, input string nm);
    int w;
    w = 0;
    while (!tx_ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (!tx_ready) begin
      failures++;
      $display("FAIL %s push timeout tx_ready=%b exp=1", nm, tx_ready);
    end
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  logic [7:0] burst [6];

  initial begin
    vec_t v;
    logic bad;

    vecs[0] = '{8'h55, 1'b0};
    vecs[1] = '{8'hA5, 1'b0};
    vecs[2] = '{8'h3C, 1'b0};
    vecs[3] = '{8'h07, 1'b1};
    vecs[4] = '{8'h03, 1'b0};
    vecs[5] = '{8'h00, 1'b0};
    vecs[6] = '{8'hFE, 1'b1};
    vecs[7] = '{8'h81, 1'b0};
    burst   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_io_tx", io_tx, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single frames, each followed by the cycle on which busy falls.
    for (int k = 0; k < 8; k++) begin
      v = vecs[k];
      push(v.data, "tbl_push");
      @(posedge clk);
      check_frame(mk_frame(v), $sformatf("tbl%0d_%02h", k, v.data));
      chk("tbl_busy_last", busy, 1);
      @(negedge clk);
      chk("tbl_busy_fall", busy, 0);
      chk("tbl_idle_tx", io_tx, 1);
      repeat (3) @(negedge clk);
    end

    // Back-to-back frames with no idle gap between them.
    push(8'hA5, "b2b_push0");
    push(8'h3C, "b2b_push1");
    check_frame(mk_frame(vecs[1]), "b2b_A5");
    check_frame(mk_frame(vecs[2]), "b2b_3C");
    @(negedge clk);
    chk("b2b_busy_fall", busy, 0);

    // Fill the FIFO with tx_valid held high and six bytes queued.
    @(negedge clk);
    fork
      begin : producer
        int w;
        for (int k = 0; k < 6; k++) begin
          tx_data  = burst[k];
          tx_valid = 1'b1;
          w = 0;
          while (!tx_ready && w < 500) begin
            @(negedge clk);
            w++;
          end
          if (!tx_ready) begin
            checks++;
            failures++;
            $display("FAIL burst_accept timeout tx_ready=%b exp=1", tx_ready);
          end
          @(posedge clk);
          #1;
        end
        tx_valid = 1'b0;
      end
      begin : consumer
        @(posedge clk);
        @(posedge clk);
        for (int k = 0; k < 6; k++) begin
          v.data = burst[k];
          v.par  = ^burst[k];
          check_frame(mk_frame(v), $sformatf("burst%0d", k));
        end
      end
      begin : full_watch
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("full_ready", tx_ready, 0);
        chk("full_count", fifo_count, 4);
        repeat (36) @(posedge clk);
        @(negedge clk);
        chk("full_ready_before_pop", tx_ready, 0);
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_pop", tx_ready, 1);
        chk("count_after_pop", fifo_count, 3);
      end
    join
    @(negedge clk);
    chk("burst_busy_fall", busy, 0);

    // Reset during data bit 3 of 0xFF, with two bytes still queued.
    push(8'hFF, "rst_push0");
    push(8'h12, "rst_push1");
    push(8'h34, "rst_push2");
    repeat (16) @(posedge clk);
    #1;
    chk("mid_count", fifo_count, 2);
    reset = 1'b1;
    #1;
    chk("mid_rst_io_tx", io_tx, 1);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", tx_ready, 1);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    v = vecs[7];
    push(v.data, "post_rst_push");
    @(posedge clk);
    check_frame(mk_frame(v), "post_rst_81");
    bad = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (io_tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    chk("post_rst_no_ghost", bad, 0);

    // Reset while the start bit is low must raise the line without waiting
    // for a clock edge.
    push(8'h00, "async_push");
    @(posedge clk);
    @(negedge clk);
    chk("async_start_low", io_tx, 0);
    reset = 1'b1;
    #1;
    chk("async_rst_io_tx", io_tx, 1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Hold tx_valid low for a long idle stretch.
    bad = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (io_tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) bad = 1'b1;
    end
    chk("idle_1000", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter: the send direction of the board UART link; the core already receives on io_rx.
- Accepts bytes from the core (debug/console output, loader echo) over a valid/ready handshake and buffers them in a small FIFO.
- Serialises each byte as 8N1 on io_tx, LSB first.
- Instantiated at the cpu top level beside the receive path.

Parameters:
CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); legal range 2 and above.
FIFO_DEPTH, 4, byte FIFO entries; must be a power of 2, 2 or more.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
tx_data  input  8  byte to send; sampled when tx_valid && tx_ready.
tx_valid  input  1  producer has a byte.
tx_ready  output  1  FIFO can accept a byte (fifo_count < FIFO_DEPTH).
io_tx  output  1  serial line; idle high; registered.
busy  output  1  high while the FSM is not IDLE or the FIFO is non-empty.
fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered (excludes the byte in flight).

Behaviour:
Interface:
- One clock (clk). Reset (reset) is asynchronous and active-high.

Reset values:
- io_tx=1, tx_ready=1, busy=0, fifo_count=0.
- FSM=IDLE, FIFO pointers=0, baud counter=0, bit index=0.

Handshake and FIFO:
- Push on a rising edge when tx_valid && tx_ready.
- tx_ready is combinational from count only; it does not depend on tx_valid.
- Full (count==FIFO_DEPTH): tx_ready=0, no push. A pop in the same cycle does not admit a push; the slot frees on the next cycle.
- Push and pop in the same cycle: count unchanged; write and read pointers both advance, wrapping modulo FIFO_DEPTH.
- Producer holds tx_data/tx_valid stable until accepted.

FSM states: IDLE, START, DATA, STOP.
- IDLE: io_tx=1. If FIFO is non-empty, pop the head into the shift register, clear the baud counter, drive io_tx=0 on the same edge, and go to START.
- Latency: byte accepted at edge N into an empty FIFO with FSM idle gives the start bit from edge N+1.
- START: hold 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0 and io_tx=shift[0].
- DATA: each bit held exactly CLKS_PER_BIT cycles; shift right, LSB first. After bit 7's period, go to STOP with io_tx=1.
- STOP: hold 1 for CLKS_PER_BIT cycles. On the period end, if the FIFO is non-empty, pop and go directly to START with io_tx=0 (no idle gap); else go to IDLE.

Timing and arithmetic:
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. A bit boundary occurs when counter==CLKS_PER_BIT-1.
- Frame length: 10*CLKS_PER_BIT cycles.
- io_tx never glitches: it changes only at bit boundaries.

Reset mid-operation:
- Asserting reset during a frame aborts it immediately: io_tx=1 asynchronously and the FIFO is flushed.
- After deassertion, the next pushed byte is sent as a complete, correct frame.

busy:
- busy = (state!=IDLE) || (count!=0).
- It falls on the edge that enters IDLE with the FIFO empty.

Optional Feature:
Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It transmits even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame = 11*CLKS_PER_BIT cycles, 8E1.
- Not defined: no PARITY state, no parity logic, 8N1, 10-bit frames.

Test Plan:
1. CLKS_PER_BIT=4, push 0x55 once -> io_tx: start 0, then 1,0,1,0,1,0,1,0, stop 1, each held exactly 4 cycles. Start begins the cycle after acceptance; frame 40 cycles; busy falls at cycle 41 after push.
2. Push 0xA5 then 0x3C on consecutive cycles -> second start bit immediately follows the first 4-cycle stop bit (no idle cycle); LSB-first data 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
3. FIFO_DEPTH=4, hold tx_valid high with 6 distinct bytes -> 5 accepted quickly (1 popped into flight + 4 buffered); tx_ready=0 and fifo_count=4. tx_ready reasserts one cycle after each pop; all 6 bytes emerge in order.
4. Reset asserted mid DATA bit 3 of 0xFF with 2 bytes queued -> io_tx=1 immediately; fifo_count=0, busy=0, tx_ready=1. A post-reset push of 0x81 sends a clean frame.
5. UART_TX_PARITY_EN defined: 0x07 -> parity bit 1; 0x03 -> parity bit 0; frame 44 cycles at CLKS_PER_BIT=4. Undefined: same bytes give 40-cycle frames with no parity bit.
6. tx_valid low throughout -> io_tx stays 1, busy stays 0, fifo_count stays 0 for 1000 cycles.
